b_full_add: RTL and testbench

// - Full adder: s = a ^ b ^ cin, cout = majority(a, b, cin), computed combinationally.
// - Generalised to a WIDTH-bit ripple-carry adder built from a 1-bit cell; WIDTH=1 is the plain full adder.
// - Also holds a registered copy of the result for synchronous consumers.
// - Leaf arithmetic block, used standalone or as the adder slice of a datapath.

---
 rtl/b_full_add_pkg.sv | 11 +
 rtl/b_full_add_fa_cell.sv | 16 +
 rtl/b_full_add.sv | 59 +++++
 tb/tb_b_full_add.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/b_full_add_pkg.sv
// Shared definitions for the b_full_add ripple-carry adder slice.
// Holds the default operand width and the carry majority function used by each bit cell.
package b_full_add_pkg;

    localparam int unsigned DEF_WIDTH = 32'd1;

    function automatic logic maj3(input logic x, input logic y, input logic z);
        return (x & y) | (x & z) | (y & z);
    endfunction

endpackage

// File: rtl/b_full_add_fa_cell.sv
// One-bit full adder cell: sum is the XOR of all three inputs,
// carry-out is their majority.
module fa_cell
    import b_full_add_pkg::*;
(
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = maj3(a, b, ci);

endmodule

// File: rtl/b_full_add.sv
// WIDTH-bit ripple-carry adder built from fa_cell slices, with a registered
// copy of the result and a valid flag for synchronous consumers.
module b_full_add
    import b_full_add_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             en,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic [WIDTH-1:0] s_q,
    output logic             cout_q,
    output logic             vld_q
);

    logic [WIDTH:0]   carry_s;
    logic [WIDTH-1:0] s_q_r;
    logic             cout_q_r;
    logic             vld_q_r;

    assign carry_s[0] = cin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        fa_cell u_cell (
            .a  (a[i]),
            .b  (b[i]),
            .ci (carry_s[i]),
            .s  (s[i]),
            .co (carry_s[i+1])
        );
    end

    assign cout = carry_s[WIDTH];

    // Result register: loads on en, holds otherwise; valid only for the cycle after a load.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_q_r    <= {WIDTH{1'b0}};
            cout_q_r <= 1'b0;
            vld_q_r  <= 1'b0;
        end else if (en) begin
            s_q_r    <= s;
            cout_q_r <= cout;
            vld_q_r  <= 1'b1;
        end else begin
            vld_q_r  <= 1'b0;
        end
    end

    assign s_q    = s_q_r;
    assign cout_q = cout_q_r;
    assign vld_q  = vld_q_r;

endmodule

// File: tb/tb_b_full_add.sv
// Scoreboard bench for b_full_add: a WIDTH=1 and a WIDTH=8 instance share
// clock, reset, cin and en; expected results are queued by the stimulus.
module tb_b_full_add;

    typedef struct packed {
        logic       w8;
        logic [7:0] s;
        logic       c;
    } cexp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       cin;
    logic       en;
    logic       a1, b1, s1, cout1, s_q1, cout_q1, vld_q1;
    logic [7:0] a8, b8, s8, s_q8;
    logic       cout8, cout_q8, vld_q8;

    int tests = 0;
    int fails = 0;

    cexp_t       cq[$];
    logic [10:0] rq[$];
    event        comb_ev;

    b_full_add #(.WIDTH(1)) u_dut1 (
        .clk(clk), .rst(rst), .a(a1), .b(b1), .cin(cin), .en(en),
        .s(s1), .cout(cout1), .s_q(s_q1), .cout_q(cout_q1), .vld_q(vld_q1)
    );

    b_full_add #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst), .a(a8), .b(b8), .cin(cin), .en(en),
        .s(s8), .cout(cout8), .s_q(s_q8), .cout_q(cout_q8), .vld_q(vld_q8)
    );

    always #5 clk = ~clk;

    function automatic void chk(string name, logic [8:0] act, logic [8:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    // Combinational monitor: drains queued expectations each time stimulus settles.
    initial begin
        cexp_t e;
        forever begin
            @(comb_ev);
            while (cq.size() > 0) begin
                e = cq.pop_front();
                if (e.w8) chk("comb8", {cout8, s8}, {e.c, e.s});
                else      chk("comb1", {7'd0, cout1, s1}, {7'd0, e.c, e.s[0]});
            end
        end
    end

    // Register monitor: samples on the falling edge, away from the load edge.
    initial begin
        logic [10:0] e;
        logic [1:0]  hold1 = 2'd0;
        logic [8:0]  hold8 = 9'd0;
        forever begin
            @(negedge clk);
            if (rst) begin
                rq.delete();
                hold1 = 2'd0;
                hold8 = 9'd0;
                chk("rst_q8", {cout_q8, s_q8}, 9'd0);
                chk("rst_q1", {7'd0, cout_q1, s_q1}, 9'd0);
                chk("rst_vld", {7'd0, vld_q1, vld_q8}, 9'd0);
            end else if (vld_q8) begin
                if (rq.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexp_vld: got vld_q=1 expected no pending load");
                end else begin
                    e = rq.pop_front();
                    hold1 = e[10:9];
                    hold8 = e[8:0];
                end
                chk("reg8", {cout_q8, s_q8}, hold8);
                chk("reg1", {7'd0, cout_q1, s_q1}, {7'd0, hold1});
                chk("vld1_hi", {8'd0, vld_q1}, 9'd1);
            end else begin
                chk("hold8", {cout_q8, s_q8}, hold8);
                chk("hold1", {7'd0, cout_q1, s_q1}, {7'd0, hold1});
                chk("vld1_lo", {8'd0, vld_q1}, 9'd0);
            end
        end
    end

    // {a,b,cin,s,cout}, hand-computed
    logic [4:0] tt [7] = '{5'b00000, 5'b11111, 5'b00110, 5'b10101,
                           5'b11001, 5'b01101, 5'b01010};

    initial begin
        logic [4:0] v;
        logic [8:0] sum9;
        logic [1:0] sum2;
        rst = 1'b1; en = 1'b0; cin = 1'b0;
        a1 = 1'b0; b1 = 1'b0; a8 = 8'h00; b8 = 8'h00;
        #1;
        chk("init_q8", {cout_q8, s_q8}, 9'd0);
        chk("init_vld", {7'd0, vld_q1, vld_q8}, 9'd0);
        @(posedge clk); #2;
        rst = 1'b0;

        for (int i = 0; i < 7; i++) begin
            v = tt[i];
            a1 = v[4]; b1 = v[3]; cin = v[2];
            #10;
            cq.push_back('{w8: 1'b0, s: {7'd0, v[1]}, c: v[0]});
            ->comb_ev;
            #1;
        end

        for (int k = 0; k < 8; k++) begin
            a1 = k[2]; b1 = k[1]; cin = k[0];
            sum2 = {1'b0, a1} + {1'b0, b1} + {1'b0, cin};
            #10;
            cq.push_back('{w8: 1'b0, s: {7'd0, sum2[0]}, c: sum2[1]});
            ->comb_ev;
            #1;
        end

        a8 = 8'hFF; b8 = 8'h01; cin = 1'b0;
        #10;
        cq.push_back('{w8: 1'b1, s: 8'h00, c: 1'b1});
        ->comb_ev;
        #1;
        a8 = 8'hFF; b8 = 8'hFF; cin = 1'b1;
        #10;
        cq.push_back('{w8: 1'b1, s: 8'hFF, c: 1'b1});
        ->comb_ev;
        #1;

        // register load then hold
        @(posedge clk); #2;
        en = 1'b1; a1 = 1'b1; b1 = 1'b1; cin = 1'b0; a8 = 8'h01; b8 = 8'h01;
        rq.push_back({2'b10, 9'h002});
        @(posedge clk); #2;
        en = 1'b0; a1 = 1'b0; b1 = 1'b0; a8 = 8'h33; b8 = 8'h44;
        @(posedge clk); #2;

        // async reset between edges while vld_q=1
        en = 1'b1; a1 = 1'b1; b1 = 1'b0; cin = 1'b0; a8 = 8'h12; b8 = 8'h34;
        rq.push_back({2'b01, 9'h046});
        @(posedge clk); #1;
        chk("pre_rst_vld", {8'd0, vld_q8}, 9'd1);
        chk("pre_rst_q8", {cout_q8, s_q8}, 9'h046);
        #1;
        rst = 1'b1; en = 1'b0; a8 = 8'h0F; b8 = 8'h01;
        #1;
        chk("async_q8", {cout_q8, s_q8}, 9'd0);
        chk("async_q1", {7'd0, cout_q1, s_q1}, 9'd0);
        chk("async_vld", {7'd0, vld_q1, vld_q8}, 9'd0);
        chk("rst_comb8", {cout8, s8}, 9'h010);

        // en high during reset must not load; first load after release
        en = 1'b1; a1 = 1'b1; b1 = 1'b1; cin = 1'b1; a8 = 8'h80; b8 = 8'h80;
        @(posedge clk); #2;
        rst = 1'b0;
        rq.push_back({2'b11, 9'h101});

        for (int n = 0; n < 1000; n++) begin
            @(posedge clk); #2;
            a8 = 8'($urandom_range(0, 255));
            b8 = 8'($urandom_range(0, 255));
            a1 = 1'($urandom_range(0, 1));
            b1 = 1'($urandom_range(0, 1));
            cin = 1'($urandom_range(0, 1));
            en = 1'($urandom_range(0, 1));
            sum9 = {1'b0, a8} + {1'b0, b8} + {8'd0, cin};
            sum2 = {1'b0, a1} + {1'b0, b1} + {1'b0, cin};
            if (en) rq.push_back({sum2, sum9});
            #1;
            cq.push_back('{w8: 1'b1, s: sum9[7:0], c: sum9[8]});
            cq.push_back('{w8: 1'b0, s: {7'd0, sum2[0]}, c: sum2[1]});
            ->comb_ev;
        end

        @(posedge clk); #2;
        en = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        chk("rq_drained", 9'(rq.size()), 9'd0);
        chk("cq_drained", 9'(cq.size()), 9'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
